// File: rtl/l1_dcache_if.sv
// Bus bundles for l1_dcache: the CPU load/store port and the l1mmu line-transfer bus.
// Each interface has a master modport for the requester and a slave modport for the responder.
interface l1_cpu_if;
    logic        cpu_req_read;
    logic        cpu_req_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    modport master (
        output cpu_req_read, cpu_req_write, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_rdata, cpu_stall
    );
    modport slave (
        input  cpu_req_read, cpu_req_write, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_rdata, cpu_stall
    );
endinterface

interface l1_mmu_if;
    logic         l1_mmu_req_read;
    logic         l1_mmu_req_write;
    logic [31:0]  l1_mmu_req_addr;
    logic [255:0] l1_mmu_write_data;
    logic         mmu_l1_read_done;
    logic         mmu_l1_write_done;
    logic [255:0] mmu_l1_read_data;

    modport master (
        output l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data,
        input  mmu_l1_read_done, mmu_l1_write_done, mmu_l1_read_data
    );
    modport slave (
        input  l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data,
        output mmu_l1_read_done, mmu_l1_write_done, mmu_l1_read_data
    );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Misses and dirty victims go through l1mmu; the MMIO window bypasses the array entirely.
module l1_dcache #(
    parameter int          INDEX_BITS  = 6,
    parameter logic [15:0] MMIO_PREFIX = 16'hFFFF
) (
    input  logic     sys_clk,
    input  logic     rst_n,
    l1_cpu_if.slave  cpu,
    l1_mmu_if.master mmu
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_REFILL,
        S_MMIO,
        S_DRAIN
    } state_t;

    state_t state, state_next;
    state_t drain_target, drain_target_next;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [255:0]        data_q [LINES];

    logic [26:0]  miss_line_q;
    logic         miss_write_q;
    logic         mmio_complete_q;
    logic [31:0]  mmio_result_q;
    logic         req_read_q;
    logic         req_write_q;
    logic [31:0]  req_addr_q;
    logic [255:0] write_data_q;

    logic                  req_any;
    logic                  is_store;
    logic                  is_mmio;
    logic                  hit;
    logic                  victim_dirty;
    logic [INDEX_BITS-1:0] cpu_index;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [7:0]            word_base;
    logic [255:0]          cur_line;
    logic [255:0]          merged_line;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic [26:0]           refill_line;

    logic        stall;
    logic [31:0] rdata;
    logic        start_wb;
    logic        start_refill;
    logic        start_mmio;
    logic        wb_done;
    logic        refill_done;
    logic        mmio_done;
    logic        mmio_accept;
    logic        store_hit;

    // A simultaneous read and write request is treated as a store.
    always_comb begin
        req_any      = cpu.cpu_req_read | cpu.cpu_req_write;
        is_store     = cpu.cpu_req_write;
        is_mmio      = (cpu.cpu_addr[31:16] == MMIO_PREFIX);
        cpu_index    = cpu.cpu_addr[5+INDEX_BITS-1:5];
        cpu_tag      = cpu.cpu_addr[31:5+INDEX_BITS];
        miss_index   = miss_line_q[INDEX_BITS-1:0];
        miss_tag     = miss_line_q[26:INDEX_BITS];
        word_base    = {cpu.cpu_addr[4:2], 5'b00000};
        cur_line     = data_q[cpu_index];
        cur_word     = cur_line[word_base +: 32];
        hit          = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag) && !is_mmio;
        victim_dirty = valid_q[cpu_index] && dirty_q[cpu_index];
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = cpu.cpu_wstrb[b] ? cpu.cpu_wdata[8*b +: 8] : cur_word[8*b +: 8];
        end
        merged_line                   = cur_line;
        merged_line[word_base +: 32]  = merged_word;
        refill_line = (state == S_IDLE) ? cpu.cpu_addr[31:5] : miss_line_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            drain_target <= S_IDLE;
        end else begin
            state        <= state_next;
            drain_target <= drain_target_next;
        end
    end

    always_comb begin
        state_next        = state;
        drain_target_next = drain_target;
        stall             = req_any;
        rdata             = '0;
        start_wb          = 1'b0;
        start_refill      = 1'b0;
        start_mmio        = 1'b0;
        wb_done           = 1'b0;
        refill_done       = 1'b0;
        mmio_done         = 1'b0;
        mmio_accept       = 1'b0;
        store_hit         = 1'b0;
        case (state)
            S_IDLE: begin
                if (mmio_complete_q) begin
                    if (req_any) begin
                        stall       = 1'b0;
                        rdata       = mmio_result_q;
                        mmio_accept = 1'b1;
                    end
                end else if (req_any) begin
                    if (is_mmio) begin
                        state_next = S_MMIO;
                        start_mmio = 1'b1;
                    end else if (hit) begin
                        stall     = 1'b0;
                        rdata     = cur_word;
                        store_hit = is_store;
                    end else if (victim_dirty) begin
                        state_next = S_WB;
                        start_wb   = 1'b1;
                    end else begin
                        state_next   = S_REFILL;
                        start_refill = 1'b1;
                    end
                end
            end
            S_WB: begin
                if (mmu.mmu_l1_write_done) begin
                    state_next        = S_DRAIN;
                    drain_target_next = S_REFILL;
                    wb_done           = 1'b1;
                end
            end
            S_REFILL: begin
                if (mmu.mmu_l1_read_done) begin
                    state_next        = S_DRAIN;
                    drain_target_next = S_IDLE;
                    refill_done       = 1'b1;
                end
            end
            S_MMIO: begin
                if (miss_write_q ? mmu.mmu_l1_write_done : mmu.mmu_l1_read_done) begin
                    state_next        = S_DRAIN;
                    drain_target_next = S_IDLE;
                    mmio_done         = 1'b1;
                end
            end
            S_DRAIN: begin
                // l1mmu keeps done high briefly after the request drops; wait it out.
                if (!mmu.mmu_l1_read_done && !mmu.mmu_l1_write_done) begin
                    state_next   = drain_target;
                    start_refill = (drain_target == S_REFILL);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            dirty_q         <= '0;
            miss_line_q     <= '0;
            miss_write_q    <= 1'b0;
            mmio_complete_q <= 1'b0;
            mmio_result_q   <= '0;
            req_read_q      <= 1'b0;
            req_write_q     <= 1'b0;
            req_addr_q      <= '0;
            write_data_q    <= '0;
        end else begin
            if (state == S_IDLE && state_next != S_IDLE) begin
                miss_line_q  <= cpu.cpu_addr[31:5];
                miss_write_q <= is_store;
            end
            if (start_wb) begin
                req_write_q  <= 1'b1;
                req_addr_q   <= {tag_q[cpu_index], cpu_index, 5'b00000};
                write_data_q <= cur_line;
            end
            if (start_refill) begin
                req_read_q   <= 1'b1;
                req_addr_q   <= {refill_line, 5'b00000};
                write_data_q <= '0;
            end
            if (start_mmio) begin
                req_read_q   <= !is_store;
                req_write_q  <= is_store;
                req_addr_q   <= cpu.cpu_addr;
                write_data_q <= {224'b0, cpu.cpu_wdata};
            end
            if (wb_done || refill_done || mmio_done) begin
                req_read_q  <= 1'b0;
                req_write_q <= 1'b0;
            end
            if (mmio_done) begin
                mmio_complete_q <= 1'b1;
                mmio_result_q   <= miss_write_q ? 32'h0 : mmu.mmu_l1_read_data[31:0];
            end
            if (mmio_accept) begin
                mmio_complete_q <= 1'b0;
            end
            if (refill_done) begin
                valid_q[miss_index] <= 1'b1;
                dirty_q[miss_index] <= 1'b0;
            end
            if (wb_done) begin
                dirty_q[miss_index] <= 1'b0;
            end
            if (store_hit) begin
                dirty_q[cpu_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage need no reset: a line is only consulted once its valid bit is set.
    always_ff @(posedge sys_clk) begin
        if (refill_done) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= mmu.mmu_l1_read_data;
        end else if (store_hit) begin
            data_q[cpu_index] <= merged_line;
        end
    end

    assign cpu.cpu_rdata          = rdata;
    assign cpu.cpu_stall          = stall;
    assign mmu.l1_mmu_req_read    = req_read_q;
    assign mmu.l1_mmu_req_write   = req_write_q;
    assign mmu.l1_mmu_req_addr    = req_addr_q;
    assign mmu.l1_mmu_write_data  = write_data_q;

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store port and `l1mmu`. It serves word accesses from 256-bit (32-byte) lines. Misses are refilled, and dirty victims are written back, through the `l1mmu` line request/done handshake. Accesses in the MMIO window bypass the array and go to `l1mmu` as single-word uncached requests.

## Interface
Parameters:
- `INDEX_BITS`, 6: number of lines is 2^INDEX_BITS; tag is addr[31:5+INDEX_BITS].
- `MMIO_PREFIX`, 16'hFFFF: address is MMIO when addr[31:16] == MMIO_PREFIX.

Ports:
- `sys_clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req_read` in 1: load request, held until `cpu_stall` is low.
- `cpu_req_write` in 1: store request, held until `cpu_stall` is low.
- `cpu_addr` in 32: byte address; bits [1:0] are ignored for word selection.
- `cpu_wdata` in 32: store data.
- `cpu_wstrb` in 4: byte enables for a store.
- `cpu_rdata` out 32: load data, valid when a load is accepted.
- `cpu_stall` out 1: request not yet complete.
- `l1_mmu_req_read` out 1: line read, or MMIO read, to `l1mmu`.
- `l1_mmu_req_write` out 1: line write, or MMIO write, to `l1mmu`.
- `l1_mmu_req_addr` out 32: line-aligned address ({addr[31:5],5'b0}); full word address for MMIO.
- `l1_mmu_write_data` out 256: victim line; for MMIO, the store word is in [31:0] and the rest is 0.
- `mmu_l1_read_done` in 1: read complete (negedge-registered by `l1mmu`).
- `mmu_l1_write_done` in 1: write complete.
- `mmu_l1_read_data` in 256: refill line; MMIO word in [31:0].

## Operation
- Storage per line: valid, dirty, tag, and 256-bit data. Word select is addr[4:2], with word 0 at bits [31:0].
- The array read is combinational. On a hit in IDLE, `cpu_stall`=0 in the same cycle and `cpu_rdata` = the selected word.
- A store hit merges `cpu_wdata` by `cpu_wstrb` at posedge and sets dirty.
- If both requests are asserted together, it is treated as a store.
- States are IDLE, WB, REFILL, MMIO, DRAIN. DRAIN holds a return-target register: REFILL or IDLE.
- IDLE:
  - MMIO address → MMIO.
  - Miss with victim valid and dirty → WB.
  - Miss otherwise → REFILL.
  - `cpu_stall`=1 whenever a request is pending and it is not a hit.
- WB: drive `l1_mmu_req_write`=1 with victim address {tag,index,5'b0} and victim data. On `mmu_l1_write_done`=1, clear dirty and go to DRAIN with target REFILL.
- REFILL: drive `l1_mmu_req_read`=1 with the miss line address. On `mmu_l1_read_done`=1:
  - write `mmu_l1_read_data` into the line;
  - set valid=1, dirty=0, tag=new;
  - go to DRAIN with target IDLE.
- The retry in IDLE then hits. A store hit applies its merge on that retry.
- MMIO:
  - forward the read or write with the word address; write data is in [31:0];
  - on the matching done, latch read data [31:0] into a result register, then go to DRAIN with target IDLE;
  - the next IDLE cycle returns `cpu_stall`=0 with `cpu_rdata` = the latched word. A one-shot "mmio_complete" flag distinguishes this from a fresh request and is cleared on acceptance.
  - MMIO never touches the array.
- DRAIN: all `l1_mmu_req_*`=0. Wait until both `mmu_l1_read_done` and `mmu_l1_write_done` are 0, then go to the target state. This is required because `l1mmu` holds done high while a request stays asserted and will not start a new transfer while done is high.
- Request signals and `l1_mmu_req_addr`/`l1_mmu_write_data` are registered and stable for the whole request.

## Timing
- Reset values:
  - all valid and dirty bits 0;
  - state IDLE;
  - `l1_mmu_req_read`/`write`=0, `l1_mmu_req_addr`=0, `l1_mmu_write_data`=0;
  - `cpu_rdata`=0 when not hitting;
  - `cpu_stall`=1 only if a request is present.
- Hit: 0 added cycles.
- Clean miss: REFILL duration, which is at least 2 `l1mmu` negedges, plus DRAIN of at least 1 cycle, plus the 1-cycle hit retry.
- Dirty miss adds one WB and one DRAIN in front.
- Done is sampled at posedge. The request is deasserted on the posedge that samples done=1.
- Reset mid-transfer: everything returns to IDLE immediately, and `l1mmu` shares `rst_n`. Line contents are invalidated, so no partial line is ever marked valid.
- `cpu_addr`/`cpu_wdata` must not change while `cpu_stall`=1. The block latches them on miss entry.

## Test plan
- Reset, then load 0x0000_0040 → REFILL with req_addr 0x0000_0040. Return line word2=0xDEADBEEF for load 0x48 → `cpu_rdata`=0xDEADBEEF. A second load of 0x48 has stall=0 in the same cycle.
- Store 0x1234_5678, wstrb 4'b0011, to a cached word holding 0xAABBCCDD → a subsequent load returns 0xAABB5678; line dirty.
- Dirty line at index 2 (tag A), then load with the same index and tag B → WB to {A,2,5'b0} carrying the modified data, DRAIN, then REFILL {B,2,5'b0}. No request is issued while done is still high.
- Load 0xFFFF_0004 → `l1_mmu_req_read` with addr 0xFFFF_0004; done with data 0x5A → `cpu_rdata`=0x0000005A; a following access of that word is still MMIO (no array fill).
- Assert `rst_n`=0 during REFILL → request drops asynchronously. After release, the same load misses again.
